// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and the single-RAM port of the arbiter.
// Pure wiring: no latency, no flow control of its own.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        if_gnt;
  logic        dm_gnt;
  logic        if_valid;
  logic        dm_valid;
  logic [63:0] if_rdata;
  logic [63:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        err;
  logic        busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_gnt, dm_gnt, if_valid, dm_valid, if_rdata, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_gnt, dm_gnt, if_valid, dm_valid, if_rdata, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one RAM, one access in flight; grant->valid is 3 cycles min.
// Requests hold until their one-cycle grant; WAIT aborts with err after TIMEOUT cycles without ack.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_starve_cnt;
  logic [WCW-1:0]  r_wait_cnt;
  logic            r_owner_dm;
  logic            r_we;
  logic [9:0]      r_addr;
  logic [63:0]     r_wdata;
  logic            r_err;
  logic [63:0]     r_if_rdata;
  logic [63:0]     r_dm_rdata;
  logic            w_dm_win;
  logic            w_if_win;
  logic            w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dm_win    = 1'b0;
    w_if_win    = 1'b0;
    w_timeout   = (r_wait_cnt == WCW'(TIMEOUT));
    case (r_state)
      IDLE: begin
        // A starved fetch overrides the data stage's normal priority.
        if (bus.dm_req && !(r_starve_cnt == 3'(STARVE_MAX) && bus.if_req)) w_dm_win = 1'b1;
        else if (bus.if_req)                                               w_if_win = 1'b1;
        if (w_dm_win || w_if_win) w_state_nxt = ISSUE;
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (bus.mem_ack || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      r_owner_dm   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_err      <= 1'b0;
          r_wait_cnt <= '0;
          if (w_dm_win) begin
            r_owner_dm <= 1'b1;
            r_we       <= bus.dm_we;
            r_addr     <= bus.dm_addr;
            r_wdata    <= bus.dm_wdata;
          end else if (w_if_win) begin
            r_owner_dm <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= bus.if_addr;
            r_wdata    <= '0;
          end
          if (w_if_win || !bus.if_req)
            r_starve_cnt <= '0;
          else if (w_dm_win && r_starve_cnt != 3'(STARVE_MAX))
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
        ISSUE: r_wait_cnt <= WCW'(1);
        WAIT: begin
          // Owner's rdata is updated on the WAIT exit so it is already valid during RESP.
          if (bus.mem_ack) begin
            if (!r_we && r_owner_dm)  r_dm_rdata <= bus.mem_rdata;
            if (!r_we && !r_owner_dm) r_if_rdata <= bus.mem_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_we && r_owner_dm)  r_dm_rdata <= '0;
            if (!r_we && !r_owner_dm) r_if_rdata <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Grants are combinational in IDLE; masking with rst_n keeps them quiet while reset is held.
  assign bus.if_gnt    = rst_n & w_if_win;
  assign bus.dm_gnt    = rst_n & w_dm_win;
  assign bus.if_valid  = (r_state == RESP) && !r_owner_dm;
  assign bus.dm_valid  = (r_state == RESP) && r_owner_dm;
  assign bus.err       = (r_state == RESP) && r_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.mem_en    = (r_state == ISSUE);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, starvation, timeout, reset and stray ack.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = '0;
    bus_if.dm_req    = 1'b0;
    bus_if.dm_we     = 1'b0;
    bus_if.dm_addr   = '0;
    bus_if.dm_wdata  = '0;
    bus_if.mem_rdata = '0;
    bus_if.mem_ack   = 1'b0;
    step(); step();
    #1;
    chk("rst_busy",   bus_if.busy,     0);
    chk("rst_mem_en", bus_if.mem_en,   0);
    chk("rst_addr",   bus_if.mem_addr, 0);
    chk("rst_ifrd",   bus_if.if_rdata, 0);
    step(); rst_n = 1'b1;

    // Fetch read, ack one cycle after mem_en.
    step(); bus_if.if_req = 1'b1; bus_if.if_addr = 10'd7; #1;
    chk("t1_if_gnt", bus_if.if_gnt, 1);
    chk("t1_dm_gnt", bus_if.dm_gnt, 0);
    step(); bus_if.if_req = 1'b0; #1;
    chk("t1_mem_en",   bus_if.mem_en,   1);
    chk("t1_mem_addr", bus_if.mem_addr, 7);
    chk("t1_mem_we",   bus_if.mem_we,   0);
    chk("t1_busy",     bus_if.busy,     1);
    step(); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 64'd5; #1;
    chk("t1_en_once", bus_if.mem_en,   0);
    chk("t1_early_v", bus_if.if_valid, 0);
    step(); bus_if.mem_ack = 1'b0; #1;
    chk("t1_if_valid", bus_if.if_valid, 1);
    chk("t1_if_rdata", bus_if.if_rdata, 5);
    chk("t1_err",      bus_if.err,      0);
    step(); #1;
    chk("t1_valid_off", bus_if.if_valid, 0);
    chk("t1_idle",      bus_if.busy,     0);

    // Simultaneous dm write and fetch: dm first, fetch in the following IDLE.
    step();
    bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b1; bus_if.dm_addr = 10'd102; bus_if.dm_wdata = 64'd6;
    bus_if.if_req = 1'b1; bus_if.if_addr = 10'd9; #1;
    chk("t2_dm_gnt", bus_if.dm_gnt, 1);
    chk("t2_if_gnt", bus_if.if_gnt, 0);
    step(); bus_if.dm_req = 1'b0; #1;
    chk("t2_mem_en",    bus_if.mem_en,    1);
    chk("t2_mem_we",    bus_if.mem_we,    1);
    chk("t2_mem_wdata", bus_if.mem_wdata, 6);
    chk("t2_mem_addr",  bus_if.mem_addr,  102);
    chk("t2_no_gnt_is", bus_if.if_gnt,    0);
    step(); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 64'hDEAD; #1;
    chk("t2_no_gnt_wt", bus_if.if_gnt, 0);
    step(); bus_if.mem_ack = 1'b0; #1;
    chk("t2_dm_valid",  bus_if.dm_valid, 1);
    chk("t2_wr_keep",   bus_if.dm_rdata, 0);
    chk("t2_no_gnt_rs", bus_if.if_gnt,   0);
    step(); #1;
    chk("t2_if_gnt2", bus_if.if_gnt, 1);
    step(); bus_if.if_req = 1'b0; #1;
    chk("t2_if_addr", bus_if.mem_addr, 9);
    chk("t2_if_we",   bus_if.mem_we,   0);
    step(); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 64'h33;
    step(); bus_if.mem_ack = 1'b0; #1;
    chk("t2_if_rdata", bus_if.if_rdata, 64'h33);
    step();

    // Both requests held: four dm grants, then fetch, repeating (counter restarts at 0).
    step();
    bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b0; bus_if.dm_addr = 10'd3;
    bus_if.if_req = 1'b1; bus_if.mem_rdata = 64'hAB;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t3_dm_gnt%0d", k), bus_if.dm_gnt, (k % 5) != 4);
      chk($sformatf("t3_if_gnt%0d", k), bus_if.if_gnt, (k % 5) == 4);
      step();
      step(); bus_if.mem_ack = 1'b1;
      step(); bus_if.mem_ack = 1'b0;
      step();
    end
    bus_if.dm_req = 1'b0; bus_if.if_req = 1'b0;
    #1;
    chk("t3_dm_rdata", bus_if.dm_rdata, 64'hAB);

    // Read without ack times out after 15 WAIT cycles.
    step(); bus_if.dm_req = 1'b1; bus_if.dm_addr = 10'd5; #1;
    chk("t4_dm_gnt", bus_if.dm_gnt, 1);
    step(); bus_if.dm_req = 1'b0;
    for (int w = 1; w <= 15; w++) begin
      step(); #1;
      chk($sformatf("t4_wait%0d_v", w), bus_if.dm_valid, 0);
    end
    chk("t4_addr_held", bus_if.mem_addr, 5);
    step(); #1;
    chk("t4_to_valid", bus_if.dm_valid, 1);
    chk("t4_to_err",   bus_if.err,      1);
    chk("t4_to_rdata", bus_if.dm_rdata, 0);
    step(); #1;
    chk("t4_err_off", bus_if.err,  0);
    chk("t4_idle",    bus_if.busy, 0);

    // Ack on exactly the 15th WAIT cycle wins over the timeout.
    step(); bus_if.dm_req = 1'b1;
    step(); bus_if.dm_req = 1'b0;
    for (int w = 1; w <= 15; w++) begin
      step();
      if (w == 15) begin
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 64'h77;
      end
    end
    step(); bus_if.mem_ack = 1'b0; #1;
    chk("t4b_valid", bus_if.dm_valid, 1);
    chk("t4b_err",   bus_if.err,      0);
    chk("t4b_rdata", bus_if.dm_rdata, 64'h77);
    step();

    // Reset during WAIT: immediate clear, late ack produces nothing.
    step(); bus_if.if_req = 1'b1; bus_if.if_addr = 10'd12; #1;
    chk("t5_if_gnt", bus_if.if_gnt, 1);
    step(); bus_if.if_req = 1'b0;
    step();
    step(); #1;
    chk("t5_busy_pre", bus_if.busy, 1);
    rst_n = 1'b0; #1;
    chk("t5_busy",     bus_if.busy,     0);
    chk("t5_mem_addr", bus_if.mem_addr, 0);
    chk("t5_if_rdata", bus_if.if_rdata, 0);
    chk("t5_dm_rdata", bus_if.dm_rdata, 0);
    chk("t5_mem_en",   bus_if.mem_en,   0);
    bus_if.if_req = 1'b1; #1;
    chk("t5_gnt_rst", bus_if.if_gnt, 0);
    bus_if.if_req = 1'b0;
    step(); rst_n = 1'b1;
    step(); bus_if.mem_ack = 1'b1;
    step(); bus_if.mem_ack = 1'b0; #1;
    chk("t5_no_valid", bus_if.if_valid, 0);
    chk("t5_no_err",   bus_if.err,      0);
    chk("t5_idle",     bus_if.busy,     0);
    step(); #1;
    chk("t5_no_valid2", bus_if.if_valid | bus_if.dm_valid, 0);
    chk("t5_idle2",     bus_if.busy,                       0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
